// File: rtl/ysyx_sim_ctrl.sv
// Simulation control for the NonSoC core: sequences core reset, counts RUN cycles and
// retired instructions, and ends the run on trap, hang or timeout with a sticky status.
module ysyx_sim_ctrl #(
    parameter int NUM_HARTS      = 1,
    parameter int RESET_CYCLES   = 3,
    parameter int TIMEOUT_CYCLES = 1650000,
    parameter int HANG_CYCLES    = 4096,
    parameter int CNT_W          = 64,
    localparam int HART_W = (NUM_HARTS > 1) ? $clog2(NUM_HARTS) : 1
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [NUM_HARTS-1:0]    commit_valid,
    input  logic [NUM_HARTS-1:0]    trap_valid,
    input  logic [32*NUM_HARTS-1:0] trap_code,
    output logic                    core_reset,
    output logic                    running,
    output logic                    done,
    output logic [2:0]              status,
    output logic [31:0]             exit_code,
    output logic [HART_W-1:0]       trap_hart,
    output logic [CNT_W-1:0]        cycle_cnt,
    output logic [CNT_W-1:0]        inst_cnt
);
    localparam int IDLE_W = (HANG_CYCLES > 0) ? $clog2(HANG_CYCLES + 1) : 1;
    localparam int HOLD_W = $clog2(RESET_CYCLES + 1);
    localparam bit HANG_EN = (HANG_CYCLES != 0);
    localparam bit TO_EN   = (TIMEOUT_CYCLES != 0);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_GOOD    = 3'd1;
    localparam logic [2:0] ST_BAD     = 3'd2;
    localparam logic [2:0] ST_HANG    = 3'd3;
    localparam logic [2:0] ST_TIMEOUT = 3'd4;

    typedef enum logic [1:0] {
        S_HOLD,
        S_RUN,
        S_DONE
    } state_t;

    state_t              r_state, w_state_nxt;
    logic [HOLD_W-1:0]   r_hold_cnt, w_hold_nxt;
    logic [IDLE_W-1:0]   r_idle_cnt, w_idle_nxt;
    logic                r_core_reset, w_core_reset_nxt;
    logic                r_running, w_running_nxt;
    logic                r_done, w_done_nxt;
    logic [2:0]          r_status, w_status_nxt;
    logic [31:0]         r_exit_code, w_exit_code_nxt;
    logic [HART_W-1:0]   r_trap_hart, w_trap_hart_nxt;
    logic [CNT_W-1:0]    r_cycle_cnt, w_cycle_nxt;
    logic [CNT_W-1:0]    r_inst_cnt, w_inst_nxt;
    logic [HART_W-1:0]   w_win;
    logic [31:0]         w_win_code;
    logic                w_exit;

    function automatic logic [CNT_W-1:0] popcount(input logic [NUM_HARTS-1:0] v);
        logic [CNT_W-1:0] n;
        n = '0;
        for (int i = 0; i < NUM_HARTS; i++) n = n + CNT_W'(v[i]);
        return n;
    endfunction

    // The idle counter must never wrap back below the hang threshold.
    function automatic logic [IDLE_W-1:0] sat_inc(input logic [IDLE_W-1:0] v);
        return (&v) ? v : v + IDLE_W'(1);
    endfunction

    // Lowest-index trapping hart wins; scan downward so it is assigned last.
    always_comb begin
        w_win      = '0;
        w_win_code = '0;
        for (int h = NUM_HARTS - 1; h >= 0; h--) begin
            if (trap_valid[h]) begin
                w_win      = HART_W'(h);
                w_win_code = trap_code[32*h +: 32];
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) r_state <= S_HOLD;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_hold_nxt       = r_hold_cnt;
        w_idle_nxt       = r_idle_cnt;
        w_core_reset_nxt = r_core_reset;
        w_running_nxt    = r_running;
        w_done_nxt       = r_done;
        w_status_nxt     = r_status;
        w_exit_code_nxt  = r_exit_code;
        w_trap_hart_nxt  = r_trap_hart;
        w_cycle_nxt      = r_cycle_cnt;
        w_inst_nxt       = r_inst_cnt;
        w_exit           = 1'b0;
        case (r_state)
            S_HOLD: begin
                w_hold_nxt = r_hold_cnt + HOLD_W'(1);
                if (w_hold_nxt == HOLD_W'(RESET_CYCLES)) begin
                    w_state_nxt      = S_RUN;
                    w_core_reset_nxt = 1'b0;
                    w_running_nxt    = 1'b1;
                end
            end
            S_RUN: begin
                w_cycle_nxt = r_cycle_cnt + CNT_W'(1);
                w_inst_nxt  = r_inst_cnt + popcount(commit_valid);
                w_idle_nxt  = (|commit_valid) ? '0 : sat_inc(r_idle_cnt);
                if (|trap_valid) begin
                    w_exit          = 1'b1;
                    w_status_nxt    = (w_win_code == 32'd0) ? ST_GOOD : ST_BAD;
                    w_exit_code_nxt = w_win_code;
                    w_trap_hart_nxt = w_win;
                end else if (HANG_EN && w_idle_nxt == IDLE_W'(HANG_CYCLES)) begin
                    w_exit       = 1'b1;
                    w_status_nxt = ST_HANG;
                end else if (TO_EN && w_cycle_nxt == CNT_W'(TIMEOUT_CYCLES)) begin
                    w_exit       = 1'b1;
                    w_status_nxt = ST_TIMEOUT;
                end
                if (w_exit) begin
                    w_state_nxt      = S_DONE;
                    w_done_nxt       = 1'b1;
                    w_running_nxt    = 1'b0;
                    w_core_reset_nxt = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_hold_cnt   <= '0;
            r_idle_cnt   <= '0;
            r_core_reset <= 1'b1;
            r_running    <= 1'b0;
            r_done       <= 1'b0;
            r_status     <= ST_IDLE;
            r_exit_code  <= '0;
            r_trap_hart  <= '0;
            r_cycle_cnt  <= '0;
            r_inst_cnt   <= '0;
        end else begin
            r_hold_cnt   <= w_hold_nxt;
            r_idle_cnt   <= w_idle_nxt;
            r_core_reset <= w_core_reset_nxt;
            r_running    <= w_running_nxt;
            r_done       <= w_done_nxt;
            r_status     <= w_status_nxt;
            r_exit_code  <= w_exit_code_nxt;
            r_trap_hart  <= w_trap_hart_nxt;
            r_cycle_cnt  <= w_cycle_nxt;
            r_inst_cnt   <= w_inst_nxt;
        end
    end

    assign core_reset = r_core_reset;
    assign running    = r_running;
    assign done       = r_done;
    assign status     = r_status;
    assign exit_code  = r_exit_code;
    assign trap_hart  = r_trap_hart;
    assign cycle_cnt  = r_cycle_cnt;
    assign inst_cnt   = r_inst_cnt;

endmodule

// File: tb/tb_ysyx_sim_ctrl.sv
// Bench for ysyx_sim_ctrl: a two-hart instance (hang enabled, timeout off) and a
// one-hart instance (timeout 50, hang off); run outcomes are checked from a queue.
module tb_ysyx_sim_ctrl;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a_n = 1'b0;
    logic [1:0]  cv_a = '0, tv_a = '0;
    logic [63:0] tc_a = '0;
    logic        cr_a, run_a, done_a;
    logic [2:0]  st_a;
    logic [31:0] ec_a;
    logic [0:0]  th_a;
    logic [63:0] cyc_a, inst_a;

    logic        rst_b_n = 1'b0;
    logic [0:0]  cv_b = '0, tv_b = '0;
    logic [31:0] tc_b = '0;
    logic        cr_b, run_b, done_b;
    logic [2:0]  st_b;
    logic [31:0] ec_b;
    logic [0:0]  th_b;
    logic [31:0] cyc_b, inst_b;

    ysyx_sim_ctrl #(.NUM_HARTS(2), .RESET_CYCLES(3), .TIMEOUT_CYCLES(0),
                    .HANG_CYCLES(16), .CNT_W(64)) u_dut_a (
        .clock(clk), .reset(rst_a_n), .commit_valid(cv_a), .trap_valid(tv_a),
        .trap_code(tc_a), .core_reset(cr_a), .running(run_a), .done(done_a),
        .status(st_a), .exit_code(ec_a), .trap_hart(th_a), .cycle_cnt(cyc_a),
        .inst_cnt(inst_a));

    ysyx_sim_ctrl #(.NUM_HARTS(1), .RESET_CYCLES(3), .TIMEOUT_CYCLES(50),
                    .HANG_CYCLES(0), .CNT_W(32)) u_dut_b (
        .clock(clk), .reset(rst_b_n), .commit_valid(cv_b), .trap_valid(tv_b),
        .trap_code(tc_b), .core_reset(cr_b), .running(run_b), .done(done_b),
        .status(st_b), .exit_code(ec_b), .trap_hart(th_b), .cycle_cnt(cyc_b),
        .inst_cnt(inst_b));

    typedef struct {
        logic [2:0]  st;
        logic [31:0] code;
        logic [63:0] hart;
        logic [63:0] cyc;
        logic [63:0] inst;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    int checks = 0;
    int failures = 0;

    function automatic exp_t mk(input logic [2:0] st, input logic [31:0] code,
                                input logic [63:0] hart, input logic [63:0] cyc,
                                input logic [63:0] inst);
        exp_t e;
        e.st = st; e.code = code; e.hart = hart; e.cyc = cyc; e.inst = inst;
        return e;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_rst(input string tag, input logic cr, input logic rn, input logic dn,
                           input logic [2:0] st, input logic [31:0] ec, input logic [63:0] th,
                           input logic [63:0] cyc, input logic [63:0] inst);
        chk({tag, ".core_reset"}, 64'(cr), 64'd1);
        chk({tag, ".running"},    64'(rn), 64'd0);
        chk({tag, ".done"},       64'(dn), 64'd0);
        chk({tag, ".status"},     64'(st), 64'd0);
        chk({tag, ".exit_code"},  64'(ec), 64'd0);
        chk({tag, ".trap_hart"},  th,      64'd0);
        chk({tag, ".cycle_cnt"},  cyc,     64'd0);
        chk({tag, ".inst_cnt"},   inst,    64'd0);
    endtask

    task automatic cmp_exit(input string tag, input exp_t e, input logic [2:0] st,
                            input logic [31:0] ec, input logic [63:0] th,
                            input logic [63:0] cyc, input logic [63:0] inst);
        chk({tag, ".status"},    64'(st), 64'(e.st));
        chk({tag, ".exit_code"}, 64'(ec), 64'(e.code));
        chk({tag, ".trap_hart"}, th,      e.hart);
        chk({tag, ".cycle_cnt"}, cyc,     e.cyc);
        chk({tag, ".inst_cnt"},  inst,    e.inst);
    endtask

    logic prev_done_a = 1'b0;
    logic prev_done_b = 1'b0;
    exp_t e_a, e_b;

    always @(negedge clk) begin
        if (done_a && !prev_done_a) begin
            checks++;
            if (q_a.size() == 0) begin
                failures++;
                $display("FAIL a.unexpected_done actual=done required=no_done");
            end else begin
                checks--;
                e_a = q_a.pop_front();
                cmp_exit("a.exit", e_a, st_a, ec_a, 64'(th_a), cyc_a, inst_a);
                chk("a.running_at_done", 64'(run_a), 64'd0);
                chk("a.core_reset_at_done", 64'(cr_a), 64'd1);
            end
        end
        if (done_b && !prev_done_b) begin
            checks++;
            if (q_b.size() == 0) begin
                failures++;
                $display("FAIL b.unexpected_done actual=done required=no_done");
            end else begin
                checks--;
                e_b = q_b.pop_front();
                cmp_exit("b.exit", e_b, st_b, ec_b, 64'(th_b), 64'(cyc_b), 64'(inst_b));
            end
        end
        prev_done_a <= done_a;
        prev_done_b <= done_b;
    end

    task automatic step_a(input logic [1:0] cv, input logic [1:0] tv, input logic [63:0] tc);
        @(negedge clk);
        cv_a = cv; tv_a = tv; tc_a = tc;
        @(posedge clk); #1;
    endtask

    task automatic step_b(input logic cv, input logic tv, input logic [31:0] tc);
        @(negedge clk);
        cv_b = cv; tv_b = tv; tc_b = tc;
        @(posedge clk); #1;
    endtask

    // Inputs are driven active during HOLD; they must have no effect.
    task automatic reset_a();
        @(negedge clk);
        rst_a_n = 1'b0; cv_a = '0; tv_a = '0; tc_a = '0;
        @(posedge clk); #1;
        chk_rst("a.rst", cr_a, run_a, done_a, st_a, ec_a, 64'(th_a), cyc_a, inst_a);
        @(negedge clk);
        rst_a_n = 1'b1; cv_a = 2'b11; tv_a = 2'b11; tc_a = 64'h0000_0009_0000_0009;
        for (int i = 1; i <= 3; i++) begin
            @(posedge clk); #1;
            chk($sformatf("a.hold%0d.core_reset", i), 64'(cr_a), (i < 3) ? 64'd1 : 64'd0);
            chk($sformatf("a.hold%0d.running", i), 64'(run_a), (i == 3) ? 64'd1 : 64'd0);
        end
        cv_a = '0; tv_a = '0; tc_a = '0;
        chk("a.entry.cycle_cnt", cyc_a, 64'd0);
        chk("a.entry.inst_cnt", inst_a, 64'd0);
        chk("a.entry.done", 64'(done_a), 64'd0);
    endtask

    task automatic reset_b();
        @(negedge clk);
        rst_b_n = 1'b0; cv_b = '0; tv_b = '0; tc_b = '0;
        @(posedge clk); #1;
        chk_rst("b.rst", cr_b, run_b, done_b, st_b, ec_b, 64'(th_b), 64'(cyc_b), 64'(inst_b));
        @(negedge clk);
        rst_b_n = 1'b1; cv_b = 1'b1; tv_b = 1'b1; tc_b = 32'h3;
        for (int i = 1; i <= 3; i++) begin
            @(posedge clk); #1;
            chk($sformatf("b.hold%0d.core_reset", i), 64'(cr_b), (i < 3) ? 64'd1 : 64'd0);
            chk($sformatf("b.hold%0d.running", i), 64'(run_b), (i == 3) ? 64'd1 : 64'd0);
        end
        cv_b = '0; tv_b = '0; tc_b = '0;
        chk("b.entry.cycle_cnt", 64'(cyc_b), 64'd0);
        chk("b.entry.inst_cnt", 64'(inst_b), 64'd0);
    endtask

    task automatic drain_a(input string tag);
        for (int i = 0; i < 4 && q_a.size() != 0; i++) step_a(2'b00, 2'b00, 64'd0);
        chk({tag, ".drained"}, 64'(q_a.size()), 64'd0);
    endtask

    task automatic drain_b(input string tag);
        for (int i = 0; i < 4 && q_b.size() != 0; i++) step_b(1'b0, 1'b0, 32'd0);
        chk({tag, ".drained"}, 64'(q_b.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=no_finish required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // 100 commits, then a good trap with a commit on the same edge.
        reset_a();
        q_a.push_back(mk(3'd1, 32'h0, 64'd0, 64'd101, 64'd101));
        for (int i = 0; i < 100; i++) step_a(2'b01, 2'b00, 64'd0);
        step_a(2'b01, 2'b01, 64'd0);
        drain_a("a.good_trap");
        for (int i = 0; i < 3; i++) step_a(2'b11, 2'b11, 64'h0000_0001_0000_0001);
        chk("a.frozen.cycle_cnt", cyc_a, 64'd101);
        chk("a.frozen.inst_cnt", inst_a, 64'd101);
        chk("a.frozen.status", 64'(st_a), 64'd1);
        chk("a.frozen.done", 64'(done_a), 64'd1);

        // Both harts trap together: hart 0 (code 5) wins.
        reset_a();
        q_a.push_back(mk(3'd2, 32'h5, 64'd0, 64'd3, 64'd4));
        step_a(2'b11, 2'b00, 64'd0);
        step_a(2'b11, 2'b00, 64'd0);
        step_a(2'b00, 2'b11, 64'h0000_0000_0000_0005);
        drain_a("a.dual_trap");

        // Only hart 1 traps.
        reset_a();
        q_a.push_back(mk(3'd2, 32'hDEADBEEF, 64'd1, 64'd2, 64'd1));
        step_a(2'b10, 2'b00, 64'd0);
        step_a(2'b00, 2'b10, 64'hDEADBEEF_0000_0000);
        drain_a("a.hart1_trap");

        // Hang on the 16th idle edge.
        reset_a();
        q_a.push_back(mk(3'd3, 32'h0, 64'd0, 64'd17, 64'd1));
        step_a(2'b01, 2'b00, 64'd0);
        for (int i = 0; i < 16; i++) step_a(2'b00, 2'b00, 64'd0);
        drain_a("a.hang");

        // A commit on idle cycle 15 restarts the idle window.
        reset_a();
        q_a.push_back(mk(3'd3, 32'h0, 64'd0, 64'd32, 64'd2));
        step_a(2'b01, 2'b00, 64'd0);
        for (int i = 0; i < 14; i++) step_a(2'b00, 2'b00, 64'd0);
        step_a(2'b01, 2'b00, 64'd0);
        for (int i = 0; i < 15; i++) step_a(2'b00, 2'b00, 64'd0);
        chk("a.hang_restart.done", 64'(done_a), 64'd0);
        chk("a.hang_restart.running", 64'(run_a), 64'd1);
        step_a(2'b00, 2'b00, 64'd0);
        drain_a("a.hang_restart");

        // Asynchronous reset in the middle of RUN.
        reset_a();
        for (int i = 0; i < 20; i++) step_a(2'b11, 2'b00, 64'd0);
        chk("a.midrun.cycle_cnt", cyc_a, 64'd20);
        chk("a.midrun.inst_cnt", inst_a, 64'd40);
        #2 rst_a_n = 1'b0;
        #1;
        chk_rst("a.async", cr_a, run_a, done_a, st_a, ec_a, 64'(th_a), cyc_a, inst_a);
        reset_a();
        q_a.push_back(mk(3'd2, 32'h7, 64'd0, 64'd6, 64'd7));
        for (int i = 0; i < 5; i++) step_a(2'b10, 2'b00, 64'd0);
        step_a(2'b11, 2'b01, 64'h0000_0000_0000_0007);
        drain_a("a.after_async");

        // Timeout at 50 cycles with alternating commits.
        reset_b();
        q_b.push_back(mk(3'd4, 32'h0, 64'd0, 64'd50, 64'd25));
        for (int i = 0; i < 49; i++) step_b(1'(i & 1), 1'b0, 32'd0);
        chk("b.pre_timeout.done", 64'(done_b), 64'd0);
        chk("b.pre_timeout.cycle_cnt", 64'(cyc_b), 64'd49);
        step_b(1'b1, 1'b0, 32'd0);
        drain_b("b.timeout");

        // Trap on cycle 50 outranks the timeout.
        reset_b();
        q_b.push_back(mk(3'd1, 32'h0, 64'd0, 64'd50, 64'd0));
        for (int i = 0; i < 49; i++) step_b(1'b0, 1'b0, 32'd0);
        step_b(1'b0, 1'b1, 32'd0);
        drain_b("b.trap_vs_timeout");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ysyx_sim_ctrl.md
Name: ysyx_sim_ctrl

Overview:
- Synthesisable simulation-control block replacing fixed-delay bench control (hard reset pulse, hard-coded `$stop` delay).
- Sits between the bench clock/reset and the NonSoC core top.
- Sequences core reset, counts cycles and retired instructions per run, and ends the run on trap, hang or timeout.
- Reports a sticky status and exit code for the bench to act on.
- Parametrised in hart count, reset length, timeout and hang window.

Parameters:
- NUM_HARTS, 1, number of cores/harts monitored.
- RESET_CYCLES, 3, rising edges core_reset stays high after reset deasserts; minimum 1.
- TIMEOUT_CYCLES, 1650000, RUN cycles before forced timeout; 0 disables.
- HANG_CYCLES, 4096, consecutive RUN cycles with no commit on any hart before hang; 0 disables.
- CNT_W, 64, width of cycle_cnt and inst_cnt.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- commit_valid  in  NUM_HARTS  bit h = hart h retired one instruction this cycle.
- trap_valid  in  NUM_HARTS  bit h = hart h executed ebreak this cycle.
- trap_code  in  32*NUM_HARTS  a0 of hart h at bits [32h+31:32h].
- core_reset  out  1  active-high reset to core(s).
- running  out  1  FSM in RUN.
- done  out  1  run finished; sticky.
- status  out  3  0 running/idle, 1 good trap, 2 bad trap, 3 hang, 4 timeout.
- exit_code  out  32  trap_code of the winning hart, else 0.
- trap_hart  out  max(1,clog2(NUM_HARTS))  index of the winning hart.
- cycle_cnt  out  CNT_W  RUN cycles elapsed.
- inst_cnt  out  CNT_W  total retired instructions, all harts.

Behaviour:
- Reset values while reset=0:
  - state HOLD, core_reset=1, running=0, done=0, status=0.
  - exit_code=0, trap_hart=0, cycle_cnt=0, inst_cnt=0, idle counter=0, hold counter=0.
- Reset asserted at any time, including mid-RUN or in DONE, returns all of the above immediately (asynchronous).
- HOLD state:
  - The hold counter increments on each rising edge after reset deasserts.
  - On the RESET_CYCLES-th edge the FSM enters RUN: core_reset drops to 0 and running rises to 1 on that same edge.
  - Inputs are ignored in HOLD.
- RUN state, on each edge:
  - cycle_cnt += 1.
  - inst_cnt += popcount(commit_valid); width extended, wraps at 2^CNT_W.
  - Idle counter clears if any commit_valid bit is set, otherwise increments.
- RUN exit conditions, evaluated on the same edge, in priority order:
  1. Any trap_valid bit set: winner is the lowest set index h. exit_code=trap_code[h], trap_hart=h, status=1 if code==0 else 2.
  2. Hang (HANG_CYCLES≠0): the idle counter's next value equals HANG_CYCLES. status=3.
  3. Timeout (TIMEOUT_CYCLES≠0): cycle_cnt's next value equals TIMEOUT_CYCLES. status=4.
- On any exit: state becomes DONE, done=1, running=0, core_reset=1. All of this is registered on that edge.
- Exit-edge accounting: commits present on the exit edge are counted, and cycle_cnt includes the exit edge.
- DONE state:
  - All outputs frozen; counters stop; later trap/commit inputs ignored.
  - Stays in DONE until reset.
- Idle counter width is clog2(HANG_CYCLES+1); it saturates and never wraps.
- No combinational path from inputs to outputs; every output is registered.

Test Plan:
- Reset deassert, RESET_CYCLES=3, no commits -> core_reset high for exactly 3 edges, then low with running=1 on the same edge; cycle_cnt=0 at entry.
- NUM_HARTS=1: commit every cycle for 100 cycles, then trap_valid with code 0 -> done=1, status=1, exit_code=0, inst_cnt=101 (trap-cycle commit included), cycle_cnt=101.
- NUM_HARTS=2: both harts trap on the same cycle, codes 0x5 and 0x0 -> trap_hart=0, status=2, exit_code=0x5.
- HANG_CYCLES=16: one commit, then none -> done on the 16th idle edge, status=3. Repeat with a commit on idle cycle 15 -> no hang; the idle counter restarts.
- TIMEOUT_CYCLES=50, HANG_CYCLES=0, no trap -> status=4, cycle_cnt=50. Trap on cycle 50 -> status=1 or 2 (trap wins).
- Reset asserted mid-RUN at cycle 20 -> all outputs return to reset values immediately; a full HOLD sequence repeats after release.
